inv_mixcolumns_seq: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the combinational mixcolumns stage used in encryption. It accepts a 128-bit state through a valid/ready handshake and transforms one 32-bit column per clock in place. It presents the result through a valid/ready output handshake. It sits between InvShiftRows/InvSubBytes/AddRoundKey in the decryption round loop and trades latency for area: one column multiplier instead of four.

---
 rtl/inv_mixcolumns_seq.sv | 160 ++++++++++++++++
 tb/tb_inv_mixcolumns_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mixcolumns_seq.sv
// ---------------------------------------------------------------------------
// inv_mixcolumns_seq
//
// Iterative AES InvMixColumns engine. A 128-bit state is accepted through a
// valid/ready handshake and transformed in place one 32-bit column per clock
// (or two columns per clock when INV_MIXCOL_DUAL_EN is defined). The finished
// state is then offered through a valid/ready output handshake.
//
// Optional build macro: INV_MIXCOL_DUAL_EN
//   undefined : one column unit, 4-cycle RUN phase
//   defined   : two column units, 2-cycle RUN phase (columns {0,1} then {2,3})
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   state_in is valid
//   in_ready   block can accept a new state (IDLE)
//   state_in   input state, column 0 = [127:96], byte 0 of a column in its MSB
//   out_valid  state_out holds the finished result (DONE)
//   out_ready  consumer accepts state_out
//   state_out  transformed state, same ordering as state_in (0 when not valid)
//   busy       high while in RUN or DONE
// ---------------------------------------------------------------------------
module inv_mixcolumns_seq #(
  parameter int COLS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

`ifdef INV_MIXCOL_DUAL_EN
  localparam int NUM_UNITS = 2;
`else
  localparam int NUM_UNITS = 1;
`endif

  localparam logic [1:0] STEP     = 2'(NUM_UNITS);
  // Column index of the first unit on the final RUN cycle.
  localparam logic [1:0] LAST_COL = 2'(COLS - NUM_UNITS);

  generate
    if (COLS != 4) begin : g_cols_check
      $error("inv_mixcolumns_seq: COLS must be 4 for AES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     col_cnt_q, col_cnt_d;
  logic [127:0]   work_q, work_d;

  // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns of a single column; byte s0 is the MSB.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Column units: unit gi works on column col_cnt_q + gi. Column c lives at
  // bits [(3-c)*32 +: 32], and (3-c)*32 is just {~c, 5'b0} for a 2-bit c.
  logic [1:0]  col_idx [NUM_UNITS];
  logic [31:0] col_out [NUM_UNITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign col_idx[gi] = col_cnt_q + 2'(gi);
      assign col_out[gi] = inv_mix_col(work_q[{~col_idx[gi], 5'b0} +: 32]);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = state_in;
          col_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          work_d[{~col_idx[u], 5'b0} +: 32] = col_out[u];
        end
        if (col_cnt_q == LAST_COL) begin
          col_cnt_d = '0;
          state_d   = DONE;
        end else begin
          col_cnt_d = col_cnt_q + STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
    end
  end

  // Outputs decode straight from the state register, so reset takes effect
  // on them immediately. state_out is forced to zero outside DONE so a
  // partially transformed register is never exposed.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = out_valid ? work_q : '0;

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
module tb_inv_mixcolumns_seq;

`ifdef INV_MIXCOL_DUAL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif
  localparam int N_RT = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  inv_mixcolumns_seq #(.COLS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Forward (inv=0) or inverse (inv=1) MixColumns on a whole state.
  function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inv);
    logic [7:0] k [4];
    logic [127:0] r;
    logic [31:0] col;
    logic [7:0] acc;
    if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
    else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[(j - rr) & 3], col[31-8*j -: 8]);
        r[127-32*c-8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one state until accepted; the expectation is queued at the
  // accepting edge. ok=0 if the DUT never became ready.
  task automatic send_state(input logic [127:0] s, input logic [127:0] exp, output bit ok);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    state_in = s;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = in_ready;
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(exp);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b state_out=%h, required 1 0 0 0",
               in_ready, out_valid, busy, state_out);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] vin [2];
    logic [127:0] vout[2];
    logic [127:0] exp;
    bit ok;
    int n;
    vin[0]  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    vout[0] = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    vin[1]  = 128'hc6c6c6c6_01010101_4d7ebdf8_00000000;
    vout[1] = 128'hc6c6c6c6_01010101_2d26314c_00000000;
    out_ready = 1'b1;  // held high before DONE must not shorten the result
    for (int v = 0; v < 2; v++) begin
      send_state(vin[v], vout[v], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL known_accept[%0d]: in_ready never 1, required accept", v);
        continue;
      end
      n = 0;
      while (n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (n == 1) begin
          checks++;
          if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL known_run_flags[%0d]: busy=%b in_ready=%b, required 1 0", v, busy, in_ready);
          end
        end
        if (out_valid) break;
      end
      checks++;
      if (n !== LAT) begin
        errors++;
        $display("FAIL known_latency[%0d]: got %0d cycles, required %0d", v, n, LAT);
      end
      exp = exp_q.pop_front();
      checks++;
      if (state_out !== exp) begin
        errors++;
        $display("FAIL known_data[%0d]: state_out=%h, required %h", v, state_out, exp);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL known_release[%0d]: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                 v, out_valid, in_ready, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] s, exp;
    bit ok;
    int n;
    bit seen;
    out_ready = 1'b0;
    s = rand_state();
    send_state(s, mix_state(s, 1'b1), ok);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok || !out_valid) begin
      errors++;
      $display("FAIL bp_reach_done: accepted=%b out_valid=%b, required 1 1", ok, out_valid);
      return;
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      state_in = rand_state();
      checks++;
      if (out_valid !== 1'b1 || state_out !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b state_out=%h, required 1 0 %h",
                 i, out_valid, in_ready, state_out, exp);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bp_ignored_input: activity seen=%b after release, required 0", seen);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [127:0] s, exp;
    bit ok;
    bit seen;
    int n;
    s = rand_state();
    send_state(s, mix_state(s, 1'b1), ok);
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || state_out !== '0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b state_out=%h, required 1 0 0 0",
               in_ready, out_valid, busy, state_out);
    end
    if (ok) void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_discard: out_valid seen=%b, required 0", seen);
    end
    s = 128'h0123456789abcdef_fedcba9876543210;
    send_state(mix_state(s, 1'b0), s, ok);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (!ok || out_valid !== 1'b1 || state_out !== exp) begin
      errors++;
      $display("FAIL after_reset: accepted=%b out_valid=%b state_out=%h, required 1 1 %h",
               ok, out_valid, state_out, exp);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int received = 0;
    int bad = 0;
    int cyc = 0;
    int drv_fail = 0;
    fork
      begin : driver
        logic [127:0] s;
        bit ok;
        for (int i = 0; i < N_RT; i++) begin
          s = rand_state();
          send_state(mix_state(s, 1'b0), s, ok);
          if (!ok) begin
            drv_fail++;
            break;
          end
        end
      end
      begin : monitor
        logic [127:0] exp;
        while (received < N_RT && cyc < N_RT * 20) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~state_out;
            checks++;
            if (state_out !== exp) begin
              errors++;
              bad++;
              if (bad <= 5)
                $display("FAIL round_trip[%0d]: state_out=%h, required %h", received, state_out, exp);
            end
            received++;
          end
        end
      end
    join
    checks++;
    if (received !== N_RT || drv_fail !== 0) begin
      errors++;
      $display("FAIL round_trip_count: received %0d (driver stalls %0d), required %0d",
               received, drv_fail, N_RT);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
